// File: rtl/uv_rf_wb_arb_if.sv
// -----------------------------------------------------------------------------
// uv_rf_wb_arb_if
// Bundle of the writeback arbiter's handshake and bus signals.
//
// Signal groups:
//   alu_wb_*  : ALU writeback producer (vld/idx/data in, rdy out)
//   lsu_wb_*  : LSU/MUL writeback producer (vld/idx/data in, rdy out)
//   rf_wr_*   : single register-file write port (registered)
//   r?_idx    : read indices under hazard check (a, b, c)
//   r?_pend   : an outstanding write targets the matching read index
//
// Modports:
//   slave  : the arbiter side (uv_rf_wb_arb)
//   master : the environment side (producers, issue logic, register file)
// -----------------------------------------------------------------------------
interface uv_rf_wb_arb_if #(
    parameter int RF_AW = 5,
    parameter int RF_DW = 32
) ();

    logic             alu_wb_vld;
    logic             alu_wb_rdy;
    logic [RF_AW-1:0] alu_wb_idx;
    logic [RF_DW-1:0] alu_wb_data;

    logic             lsu_wb_vld;
    logic             lsu_wb_rdy;
    logic [RF_AW-1:0] lsu_wb_idx;
    logic [RF_DW-1:0] lsu_wb_data;

    logic             rf_wr_vld;
    logic [RF_AW-1:0] rf_wr_idx;
    logic [RF_DW-1:0] rf_wr_data;

    logic [RF_AW-1:0] ra_idx;
    logic [RF_AW-1:0] rb_idx;
    logic [RF_AW-1:0] rc_idx;
    logic             ra_pend;
    logic             rb_pend;
    logic             rc_pend;

    modport slave (
        input  alu_wb_vld, alu_wb_idx, alu_wb_data,
        output alu_wb_rdy,
        input  lsu_wb_vld, lsu_wb_idx, lsu_wb_data,
        output lsu_wb_rdy,
        output rf_wr_vld, rf_wr_idx, rf_wr_data,
        input  ra_idx, rb_idx, rc_idx,
        output ra_pend, rb_pend, rc_pend
    );

    modport master (
        output alu_wb_vld, alu_wb_idx, alu_wb_data,
        input  alu_wb_rdy,
        output lsu_wb_vld, lsu_wb_idx, lsu_wb_data,
        input  lsu_wb_rdy,
        input  rf_wr_vld, rf_wr_idx, rf_wr_data,
        output ra_idx, rb_idx, rc_idx,
        input  ra_pend, rb_pend, rc_pend
    );

endinterface

// File: rtl/uv_rf_wb_arb.sv
// -----------------------------------------------------------------------------
// uv_rf_wb_arb
// Writeback arbiter driving the single register-file write port from the ALU
// pipe and the long-latency LSU/MUL path. LSU results are held in a small
// load queue; the ALU has priority unless a starvation counter forces the
// queue head out. Pending-write flags let issue logic stall on hazards.
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   wb_io  : uv_rf_wb_arb_if.slave (ALU/LSU handshakes, rf_wr_* write port,
//            ra/rb/rc hazard indices and pend flags)
//
// Parameters:
//   RF_AW  : register index width
//   RF_DW  : register data width
//   LQ_AW  : load-queue address width
//   LQ_DP  : load-queue depth (2**LQ_AW)
//   STV_TH : consecutive denied cycles before a forced drain (1..15)
//
// Build option:
//   UV_WB_LSU_BYPASS_EN : when defined, an LSU write arriving with the queue
//   empty and no ALU handshake goes straight to the write port (1-cycle
//   latency). Otherwise every LSU write is queued first (2-cycle minimum).
// -----------------------------------------------------------------------------
module uv_rf_wb_arb #(
    parameter int RF_AW  = 5,
    parameter int RF_DW  = 32,
    parameter int LQ_AW  = 2,
    parameter int LQ_DP  = 2**LQ_AW,
    parameter int STV_TH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uv_rf_wb_arb_if.slave  wb_io
);

    localparam int               CNT_W      = LQ_AW + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL_C = CNT_W'(LQ_DP);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1'b1);
    localparam logic [LQ_AW-1:0] PTR_ZERO_C = {LQ_AW{1'b0}};
    localparam logic [LQ_AW-1:0] PTR_ONE_C  = LQ_AW'(1'b1);
    localparam logic [3:0]       STV_LAST_C = 4'(STV_TH - 1);
    localparam logic [RF_AW-1:0] IDX_ZERO_C = {RF_AW{1'b0}};
    localparam logic [RF_DW-1:0] DAT_ZERO_C = {RF_DW{1'b0}};

    // Load-queue storage (no reset: occupancy gates every read)
    logic [RF_AW-1:0] lq_idx_q  [LQ_DP];
    logic [RF_DW-1:0] lq_data_q [LQ_DP];

    // Queue control
    logic [LQ_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LQ_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // Starvation tracking
    logic [3:0]       stv_q,    stv_d;
    logic             drain_q,  drain_d;

    // Write-port register
    logic             rf_vld_q,  rf_vld_d;
    logic [RF_AW-1:0] rf_idx_q,  rf_idx_d;
    logic [RF_DW-1:0] rf_data_q, rf_data_d;

    // Handshake and selection decode
    logic             lq_empty_s;
    logic             lq_full_s;
    logic             alu_hs_s;
    logic             lsu_hs_s;
    logic             alu_nz_s;
    logic             lsu_nz_s;
    logic             push_s;
    logic             pop_s;
    logic             bypass_s;

    // Hazard-check helpers
    logic [LQ_AW-1:0]            lq_off_s [LQ_DP];
    logic [LQ_DP-1:0]            lq_occ_s;
    logic [LQ_DP-1:0][RF_AW-1:0] lq_idx_s;

    // A read index is pending if it is non-zero and hits either an occupied
    // queue slot or the write currently sitting in the output register.
    function automatic logic pend_f(
        input logic [RF_AW-1:0]            idx,
        input logic [LQ_DP-1:0]            occ,
        input logic [LQ_DP-1:0][RF_AW-1:0] ent_idx,
        input logic                        wr_vld,
        input logic [RF_AW-1:0]            wr_idx
    );
        logic hit;
        hit = wr_vld & (wr_idx == idx);
        for (int i = 0; i < LQ_DP; i++) begin
            hit = hit | (occ[i] & (ent_idx[i] == idx));
        end
        return (idx != IDX_ZERO_C) & hit;
    endfunction

    // Handshake decode; LSU readiness depends on occupancy only
    always_comb begin
        lq_empty_s = (cnt_q == CNT_ZERO_C);
        lq_full_s  = (cnt_q == CNT_FULL_C);
        alu_hs_s   = wb_io.alu_wb_vld & ~drain_q;
        lsu_hs_s   = wb_io.lsu_wb_vld & ~lq_full_s;
        alu_nz_s   = (wb_io.alu_wb_idx != IDX_ZERO_C);
        lsu_nz_s   = (wb_io.lsu_wb_idx != IDX_ZERO_C);
    end

    // Write-port selection: forced drain, ALU, queue head, then optional bypass
    always_comb begin
        pop_s     = 1'b0;
        bypass_s  = 1'b0;
        rf_vld_d  = 1'b0;
        rf_idx_d  = rf_idx_q;
        rf_data_d = rf_data_q;
        if (drain_q && !lq_empty_s) begin
            pop_s     = 1'b1;
            rf_vld_d  = 1'b1;
            rf_idx_d  = lq_idx_q[rd_ptr_q];
            rf_data_d = lq_data_q[rd_ptr_q];
        end else if (alu_hs_s && alu_nz_s) begin
            rf_vld_d  = 1'b1;
            rf_idx_d  = wb_io.alu_wb_idx;
            rf_data_d = wb_io.alu_wb_data;
        end else if (!lq_empty_s) begin
            pop_s     = 1'b1;
            rf_vld_d  = 1'b1;
            rf_idx_d  = lq_idx_q[rd_ptr_q];
            rf_data_d = lq_data_q[rd_ptr_q];
`ifdef UV_WB_LSU_BYPASS_EN
        end else if (lsu_hs_s && !alu_hs_s && lsu_nz_s) begin
            // Queue is empty here, so skipping it cannot reorder LSU results.
            bypass_s  = 1'b1;
            rf_vld_d  = 1'b1;
            rf_idx_d  = wb_io.lsu_wb_idx;
            rf_data_d = wb_io.lsu_wb_data;
`endif
        end else begin
            rf_vld_d  = 1'b0;
        end
    end

    // Queue pointers/occupancy and starvation tracking
    always_comb begin
        // Index-0 writes complete their handshake but are dropped.
        push_s   = lsu_hs_s & lsu_nz_s & ~bypass_s;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE_C) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE_C) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE_C;
            2'b01:   cnt_d = cnt_q - CNT_ONE_C;
            default: cnt_d = cnt_q;
        endcase
        if (lq_empty_s || pop_s) begin
            stv_d   = 4'd0;
            drain_d = 1'b0;
        end else begin
            // Saturating at the threshold keeps the compare a single equality.
            drain_d = (stv_q == STV_LAST_C);
            stv_d   = (stv_q == STV_LAST_C) ? stv_q : (stv_q + 4'd1);
        end
    end

    // Slot occupancy: slot i holds live data if its distance from the read
    // pointer (mod depth) is below the current count
    always_comb begin
        for (int i = 0; i < LQ_DP; i++) begin
            lq_off_s[i] = LQ_AW'(i) - rd_ptr_q;
            lq_occ_s[i] = ({1'b0, lq_off_s[i]} < cnt_q);
            lq_idx_s[i] = lq_idx_q[i];
        end
    end

    // Control and write-port state, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= PTR_ZERO_C;
            rd_ptr_q  <= PTR_ZERO_C;
            cnt_q     <= CNT_ZERO_C;
            stv_q     <= 4'd0;
            drain_q   <= 1'b0;
            rf_vld_q  <= 1'b0;
            rf_idx_q  <= IDX_ZERO_C;
            rf_data_q <= DAT_ZERO_C;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            stv_q     <= stv_d;
            drain_q   <= drain_d;
            rf_vld_q  <= rf_vld_d;
            rf_idx_q  <= rf_idx_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Load-queue entry write at the tail
    always_ff @(posedge clk) begin
        if (push_s) begin
            lq_idx_q[wr_ptr_q]  <= wb_io.lsu_wb_idx;
            lq_data_q[wr_ptr_q] <= wb_io.lsu_wb_data;
        end
    end

    assign wb_io.alu_wb_rdy = ~drain_q;
    assign wb_io.lsu_wb_rdy = ~lq_full_s;
    assign wb_io.rf_wr_vld  = rf_vld_q;
    assign wb_io.rf_wr_idx  = rf_idx_q;
    assign wb_io.rf_wr_data = rf_data_q;
    assign wb_io.ra_pend    = pend_f(wb_io.ra_idx, lq_occ_s, lq_idx_s, rf_vld_q, rf_idx_q);
    assign wb_io.rb_pend    = pend_f(wb_io.rb_idx, lq_occ_s, lq_idx_s, rf_vld_q, rf_idx_q);
    assign wb_io.rc_pend    = pend_f(wb_io.rc_idx, lq_occ_s, lq_idx_s, rf_vld_q, rf_idx_q);

endmodule

// File: tb/tb_uv_rf_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_uv_rf_wb_arb
// Self-checking bench for uv_rf_wb_arb: directed scenarios with literal
// expectations, then randomized traffic, all compared each cycle against a
// queue-based reference model of the writeback rules.
// -----------------------------------------------------------------------------
module tb_uv_rf_wb_arb;

    localparam int RF_AW  = 5;
    localparam int RF_DW  = 32;
    localparam int LQ_AW  = 2;
    localparam int LQ_DP  = 4;
    localparam int STV_TH = 4;
`ifdef UV_WB_LSU_BYPASS_EN
    localparam int LSU_LAT = 1;
`else
    localparam int LSU_LAT = 2;
`endif

    logic clk;
    logic rst_n;

    uv_rf_wb_arb_if #(.RF_AW(RF_AW), .RF_DW(RF_DW)) wb_if ();

    uv_rf_wb_arb #(
        .RF_AW (RF_AW),
        .RF_DW (RF_DW),
        .LQ_AW (LQ_AW),
        .LQ_DP (LQ_DP),
        .STV_TH(STV_TH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wb_io(wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [RF_AW-1:0] idx;
        logic [RF_DW-1:0] data;
    } ent_t;

    ent_t             mq[$];
    int               streak;
    logic             m_vld;
    logic [RF_AW-1:0] m_idx;
    logic [RF_DW-1:0] m_data;

    int n_chk;
    int n_fail;

    function automatic logic m_drain();
        return (streak >= STV_TH);
    endfunction

    function automatic logic m_pend(input logic [RF_AW-1:0] idx);
        if (idx == 5'd0) return 1'b0;
        if (m_vld && (m_idx == idx)) return 1'b1;
        foreach (mq[i]) if (mq[i].idx == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        streak = 0;
        m_vld  = 1'b0;
        m_idx  = 5'd0;
        m_data = 32'd0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic compare();
        chk("rf_wr_vld", 64'(wb_if.rf_wr_vld), 64'(m_vld));
        if (m_vld) begin
            chk("rf_wr_idx",  64'(wb_if.rf_wr_idx),  64'(m_idx));
            chk("rf_wr_data", 64'(wb_if.rf_wr_data), 64'(m_data));
        end
        chk("alu_wb_rdy", 64'(wb_if.alu_wb_rdy), 64'(!m_drain()));
        chk("lsu_wb_rdy", 64'(wb_if.lsu_wb_rdy), 64'(mq.size() != LQ_DP));
        chk("ra_pend", 64'(wb_if.ra_pend), 64'(m_pend(wb_if.ra_idx)));
        chk("rb_pend", 64'(wb_if.rb_pend), 64'(m_pend(wb_if.rb_idx)));
        chk("rc_pend", 64'(wb_if.rc_pend), 64'(m_pend(wb_if.rc_idx)));
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic drain, nonempty, alu_hs, lsu_hs, popped, byp;
        ent_t e;
        drain    = m_drain();
        nonempty = (mq.size() > 0);
        alu_hs   = wb_if.alu_wb_vld && !drain;
        lsu_hs   = wb_if.lsu_wb_vld && (mq.size() != LQ_DP);
        popped   = 1'b0;
        byp      = 1'b0;
        m_vld    = 1'b0;
        if (drain && nonempty) begin
            e = mq.pop_front(); popped = 1'b1;
            m_vld = 1'b1; m_idx = e.idx; m_data = e.data;
        end else if (alu_hs && wb_if.alu_wb_idx != 5'd0) begin
            m_vld = 1'b1; m_idx = wb_if.alu_wb_idx; m_data = wb_if.alu_wb_data;
        end else if (nonempty) begin
            e = mq.pop_front(); popped = 1'b1;
            m_vld = 1'b1; m_idx = e.idx; m_data = e.data;
        end
`ifdef UV_WB_LSU_BYPASS_EN
        else if (lsu_hs && !alu_hs && wb_if.lsu_wb_idx != 5'd0) begin
            byp = 1'b1;
            m_vld = 1'b1; m_idx = wb_if.lsu_wb_idx; m_data = wb_if.lsu_wb_data;
        end
`endif
        streak = (nonempty && !popped) ? streak + 1 : 0;
        if (lsu_hs && wb_if.lsu_wb_idx != 5'd0 && !byp) begin
            e.idx  = wb_if.lsu_wb_idx;
            e.data = wb_if.lsu_wb_data;
            mq.push_back(e);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                         input logic lv, input logic [4:0] li, input logic [31:0] ld,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc);
        wb_if.alu_wb_vld  = av;
        wb_if.alu_wb_idx  = ai;
        wb_if.alu_wb_data = ad;
        wb_if.lsu_wb_vld  = lv;
        wb_if.lsu_wb_idx  = li;
        wb_if.lsu_wb_data = ld;
        wb_if.ra_idx      = ra;
        wb_if.rb_idx      = rb;
        wb_if.rc_idx      = rc;
    endtask

    // One clock: drive on the falling edge, check, then step the model
    task automatic cycle(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                         input logic lv, input logic [4:0] li, input logic [31:0] ld,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc);
        @(negedge clk);
        drive(av, ai, ad, lv, li, ld, ra, rb, rc);
        #1;
        compare();
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    endtask

    // Single LSU write with the ALU idle; checks latency and rb_pend window
    task automatic lsu_probe(input logic [4:0] idx, input logic [31:0] data);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, idx, data, 5'd0, idx, 5'd0);
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, idx, 5'd0);
            chk("lsu_lat_vld", 64'(wb_if.rf_wr_vld), 64'(k == LSU_LAT));
            chk("lsu_rb_pend", 64'(wb_if.rb_pend), 64'(k <= LSU_LAT));
            if (k == LSU_LAT) begin
                chk("lsu_lat_idx",  64'(wb_if.rf_wr_idx),  64'(idx));
                chk("lsu_lat_data", 64'(wb_if.rf_wr_data), 64'(data));
            end
        end
    endtask

    initial begin
        int alu_pct;
        int lsu_pct;
        logic [4:0] ri [5];
        n_chk  = 0;
        n_fail = 0;
        model_reset();

        // Reset values
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd3, 5'd1);
        #3;
        compare();
        chk("rst_wr_vld",  64'(wb_if.rf_wr_vld),  64'd0);
        chk("rst_wr_idx",  64'(wb_if.rf_wr_idx),  64'd0);
        chk("rst_wr_data", 64'(wb_if.rf_wr_data), 64'd0);
        chk("rst_alu_rdy", 64'(wb_if.alu_wb_rdy), 64'd1);
        chk("rst_lsu_rdy", 64'(wb_if.lsu_wb_rdy), 64'd1);
        chk("rst_ra_pend", 64'(wb_if.ra_pend),    64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU write, one-cycle latency, one-cycle pulse
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0);
        chk("alu_wr_vld",  64'(wb_if.rf_wr_vld),  64'd1);
        chk("alu_wr_idx",  64'(wb_if.rf_wr_idx),  64'd5);
        chk("alu_wr_data", 64'(wb_if.rf_wr_data), 64'hDEADBEEF);
        chk("alu_ra_pend", 64'(wb_if.ra_pend),    64'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd0);
        chk("alu_wr_drop", 64'(wb_if.rf_wr_vld),  64'd0);
        chk("alu_ra_clr",  64'(wb_if.ra_pend),    64'd0);

        // LSU write latency
        lsu_probe(5'd3, 32'h11);

        // Fill the queue under ALU pressure, then forced drain and full+pop
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 5'd2, $urandom, 1'b1, 5'(20 + k), 32'(32'hA0 + k), 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, $urandom, 1'b1, 5'd24, 32'hA4, 5'd0, 5'd0, 5'd0);
        chk("full_lsu_rdy", 64'(wb_if.lsu_wb_rdy), 64'd0);
        chk("full_alu_rdy", 64'(wb_if.alu_wb_rdy), 64'd1);
        cycle(1'b1, 5'd2, $urandom, 1'b1, 5'd25, 32'hE5, 5'd0, 5'd0, 5'd0);
        chk("drain_alu_rdy",  64'(wb_if.alu_wb_rdy), 64'd0);
        chk("drain_lsu_rdy",  64'(wb_if.lsu_wb_rdy), 64'd0);
        cycle(1'b1, 5'd2, $urandom, 1'b1, 5'd25, 32'hE5, 5'd0, 5'd0, 5'd0);
        chk("post_alu_rdy",   64'(wb_if.alu_wb_rdy), 64'd1);
        chk("post_lsu_rdy",   64'(wb_if.lsu_wb_rdy), 64'd1);
        chk("drain_wr_vld",   64'(wb_if.rf_wr_vld),  64'd1);
        chk("drain_wr_idx",   64'(wb_if.rf_wr_idx),  64'd20);
        chk("drain_wr_data",  64'(wb_if.rf_wr_data), 64'hA0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd25);
        chk("retry_rc_pend",  64'(wb_if.rc_pend),    64'd1);
        idle(8);

        // Index 0 from both sources
        cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0, 5'd0);
        chk("z_alu_rdy", 64'(wb_if.alu_wb_rdy), 64'd1);
        chk("z_lsu_rdy", 64'(wb_if.lsu_wb_rdy), 64'd1);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
            chk("z_wr_vld",  64'(wb_if.rf_wr_vld), 64'd0);
            chk("z_ra_pend", 64'(wb_if.ra_pend),   64'd0);
        end

        // Reset with three queued entries
        cycle(1'b1, 5'd2, 32'h1, 1'b1, 5'd10, 32'hB0, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB1, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, 32'h3, 1'b1, 5'd12, 32'hB2, 5'd0, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, 32'h4, 1'b0, 5'd0, 32'd0, 5'd12, 5'd10, 5'd0);
        chk("pre_rst_ra_pend", 64'(wb_if.ra_pend), 64'd1);
        chk("pre_rst_rb_pend", 64'(wb_if.rb_pend), 64'd1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd10, 5'd2);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("mid_rst_wr_vld",  64'(wb_if.rf_wr_vld),  64'd0);
        chk("mid_rst_ra_pend", 64'(wb_if.ra_pend),    64'd0);
        chk("mid_rst_rb_pend", 64'(wb_if.rb_pend),    64'd0);
        chk("mid_rst_rc_pend", 64'(wb_if.rc_pend),    64'd0);
        chk("mid_rst_lsu_rdy", 64'(wb_if.lsu_wb_rdy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        lsu_probe(5'd9, 32'h99);

        // Randomized traffic with varying ALU pressure
        for (int seg = 0; seg < 10; seg++) begin
            alu_pct = (seg % 4 == 3) ? 100 : 10 + 30 * (seg % 4);
            lsu_pct = 20 + 15 * (seg % 5);
            for (int n = 0; n < 200; n++) begin
                for (int j = 0; j < 5; j++)
                    ri[j] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                        : 5'($urandom_range(0, 7));
                cycle($urandom_range(0, 99) < alu_pct, ri[0], $urandom,
                      $urandom_range(0, 99) < lsu_pct, ri[1], $urandom,
                      ri[2], ri[3], ri[4]);
            end
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
